// File: rtl/ps2_key_event_queue.sv
// ps2_key_event_queue: PS/2 set-2 scan-code parser with key-state table and event FIFO
// clk/rst           : single clock, synchronous active-high reset
// scanCode/Ready    : scan-code byte and its one-cycle strobe
// asciiKeyAddress   : key-state read address; keyValue returns it one cycle later
// evtPop/evtValid   : event queue consume / non-empty
// evtData/evtCount  : head event {make,shift,ctrl,alt,ext,2'b0,code[8:0]} / occupancy
// overflow/ovfClear : sticky dropped-event flag and its clear
module ps2_key_event_queue #(
    parameter int ADDR_W        = 9,
    parameter int DATA_W        = 32,
    parameter int FIFO_DEPTH    = 16,
    parameter int REPEAT_FILTER = 1
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [7:0]                  scanCode,
    input  logic                        scanCodeReady,
    input  logic [ADDR_W-1:0]           asciiKeyAddress,
    output logic [DATA_W-1:0]           keyValue,
    input  logic                        evtPop,
    output logic                        evtValid,
    output logic [15:0]                 evtData,
    output logic [$clog2(FIFO_DEPTH):0] evtCount,
    output logic                        overflow,
    input  logic                        ovfClear
);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int NK = 1 << ADDR_W;
    localparam logic [8:0] A_SHIFT = 9'h100, A_CTRL = 9'h101, A_ALT = 9'h102;
    localparam logic [1:0] IDLE = 2'd0, BRK = 2'd1, EXT = 2'd2, EXT_BRK = 2'd3;

    // Returns {mapped, code}; letters map to lowercase ASCII, specials above 0xFF.
    function automatic logic [9:0] xlate(input logic ext, input logic [7:0] sc);
        if (ext)
            case (sc)
                8'h75: xlate = {1'b1, 9'h103};
                8'h72: xlate = {1'b1, 9'h104};
                8'h6B: xlate = {1'b1, 9'h105};
                8'h74: xlate = {1'b1, 9'h106};
                8'h14: xlate = {1'b1, A_CTRL};
                8'h11: xlate = {1'b1, A_ALT};
                default: xlate = '0;
            endcase
        else
            case (sc)
                8'h1C: xlate = {1'b1, 9'h061}; 8'h32: xlate = {1'b1, 9'h062};
                8'h21: xlate = {1'b1, 9'h063}; 8'h23: xlate = {1'b1, 9'h064};
                8'h24: xlate = {1'b1, 9'h065}; 8'h2B: xlate = {1'b1, 9'h066};
                8'h34: xlate = {1'b1, 9'h067}; 8'h33: xlate = {1'b1, 9'h068};
                8'h43: xlate = {1'b1, 9'h069}; 8'h3B: xlate = {1'b1, 9'h06A};
                8'h42: xlate = {1'b1, 9'h06B}; 8'h4B: xlate = {1'b1, 9'h06C};
                8'h3A: xlate = {1'b1, 9'h06D}; 8'h31: xlate = {1'b1, 9'h06E};
                8'h44: xlate = {1'b1, 9'h06F}; 8'h4D: xlate = {1'b1, 9'h070};
                8'h15: xlate = {1'b1, 9'h071}; 8'h2D: xlate = {1'b1, 9'h072};
                8'h1B: xlate = {1'b1, 9'h073}; 8'h2C: xlate = {1'b1, 9'h074};
                8'h3C: xlate = {1'b1, 9'h075}; 8'h2A: xlate = {1'b1, 9'h076};
                8'h1D: xlate = {1'b1, 9'h077}; 8'h22: xlate = {1'b1, 9'h078};
                8'h35: xlate = {1'b1, 9'h079}; 8'h1A: xlate = {1'b1, 9'h07A};
                8'h45: xlate = {1'b1, 9'h030}; 8'h16: xlate = {1'b1, 9'h031};
                8'h1E: xlate = {1'b1, 9'h032}; 8'h26: xlate = {1'b1, 9'h033};
                8'h25: xlate = {1'b1, 9'h034}; 8'h2E: xlate = {1'b1, 9'h035};
                8'h36: xlate = {1'b1, 9'h036}; 8'h3D: xlate = {1'b1, 9'h037};
                8'h3E: xlate = {1'b1, 9'h038}; 8'h46: xlate = {1'b1, 9'h039};
                8'h29: xlate = {1'b1, 9'h020}; 8'h5A: xlate = {1'b1, 9'h00D};
                8'h76: xlate = {1'b1, 9'h01B}; 8'h66: xlate = {1'b1, 9'h008};
                8'h0D: xlate = {1'b1, 9'h009};
                8'h12, 8'h59: xlate = {1'b1, A_SHIFT};
                8'h14: xlate = {1'b1, A_CTRL};
                8'h11: xlate = {1'b1, A_ALT};
                default: xlate = '0;
            endcase
    endfunction

    logic [1:0]        state_q, state_d;
    logic [NK-1:0]     keys_q, keys_d;
    logic              lsh_q, rsh_q, lct_q, rct_q, lal_q, ral_q;
    logic              lsh_d, rsh_d, lct_d, rct_d, lal_d, ral_d;
    logic [15:0]       mem_q [FIFO_DEPTH];
    logic [PW-1:0]     wp_q, rp_q;
    logic [PW:0]       cnt_q;
    logic              ovf_q;
    logic [DATA_W-1:0] kv_q;
    logic [9:0]        map;
    logic [8:0]        code, ecode;
    logic [ADDR_W-1:0] idx, up_idx;
    logic [15:0]       evt;
    logic              brk, ext, mk, letter, is_mod, shift_now, done, hit, held;
    logic              push, pop, full, wr, drop, rd;

    always_comb begin
        brk       = state_q == BRK || state_q == EXT_BRK;
        ext       = state_q == EXT || state_q == EXT_BRK;
        mk        = !brk;
        map       = xlate(ext, scanCode);
        code      = map[8:0];
        letter    = code >= 9'h061 && code <= 9'h07A;
        is_mod    = code == A_SHIFT || code == A_CTRL || code == A_ALT;
        shift_now = lsh_q | rsh_q;
        ecode     = letter && shift_now ? code - 9'h020 : code;
        idx       = ADDR_W'(code);
        up_idx    = ADDR_W'(code - 9'h020);
        // A prefix byte only counts as a prefix the first time it appears in a code.
        done      = scanCodeReady && scanCode != 8'hE1 && !(scanCode == 8'hF0 && !brk)
                    && !(scanCode == 8'hE0 && !ext);
        hit       = done && map[9];
        state_d   = !scanCodeReady || scanCode == 8'hE1 ? state_q
                  : scanCode == 8'hF0 && !brk ? (ext ? EXT_BRK : BRK)
                  : scanCode == 8'hE0 && !ext ? (brk ? EXT_BRK : EXT) : IDLE;
        lsh_d     = hit && code == A_SHIFT && scanCode == 8'h12 ? mk : lsh_q;
        rsh_d     = hit && code == A_SHIFT && scanCode == 8'h59 ? mk : rsh_q;
        lct_d     = hit && code == A_CTRL && !ext ? mk : lct_q;
        rct_d     = hit && code == A_CTRL && ext ? mk : rct_q;
        lal_d     = hit && code == A_ALT && !ext ? mk : lal_q;
        ral_d     = hit && code == A_ALT && ext ? mk : ral_q;
        held      = code == A_SHIFT ? (scanCode == 8'h12 ? lsh_q : rsh_q)
                  : code == A_CTRL ? (ext ? rct_q : lct_q)
                  : code == A_ALT ? (ext ? ral_q : lal_q)
                  : letter ? keys_q[idx] | keys_q[up_idx] : keys_q[idx];
        keys_d    = keys_q;
        // Modifier entries are derived from the side flags, not stored in the table.
        if (hit && !is_mod) begin
            if (letter && brk) begin
                keys_d[idx]    = 1'b0;
                keys_d[up_idx] = 1'b0;
            end else
                keys_d[ADDR_W'(ecode)] = mk;
        end
        push      = hit && !(mk && held && REPEAT_FILTER != 0);
        evt       = {mk, lsh_d | rsh_d, lct_d | rct_d, lal_d | ral_d, ext, 2'b00, ecode};
        rd        = asciiKeyAddress == ADDR_W'(A_SHIFT) ? lsh_q | rsh_q
                  : asciiKeyAddress == ADDR_W'(A_CTRL) ? lct_q | rct_q
                  : asciiKeyAddress == ADDR_W'(A_ALT) ? lal_q | ral_q
                  : keys_q[asciiKeyAddress];
        pop       = evtPop && cnt_q != '0;
        full      = cnt_q == (PW+1)'(FIFO_DEPTH);
        wr        = push && (!full || pop);
        drop      = push && full && !pop;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            keys_q  <= '0;
            {lsh_q, rsh_q, lct_q, rct_q, lal_q, ral_q} <= '0;
            wp_q    <= '0;
            rp_q    <= '0;
            cnt_q   <= '0;
            ovf_q   <= 1'b0;
            kv_q    <= '0;
        end else begin
            state_q <= state_d;
            keys_q  <= keys_d;
            {lsh_q, rsh_q, lct_q, rct_q, lal_q, ral_q} <= {lsh_d, rsh_d, lct_d, rct_d, lal_d, ral_d};
            if (wr) wp_q <= wp_q + PW'(1);
            if (pop) rp_q <= rp_q + PW'(1);
            cnt_q   <= cnt_q + (PW+1)'(wr) - (PW+1)'(pop);
            ovf_q   <= drop || (ovf_q && !ovfClear);
            kv_q    <= DATA_W'(rd);
        end
    end

    always_ff @(posedge clk) begin
        if (wr) mem_q[wp_q] <= evt;
    end

    assign keyValue = kv_q;
    assign evtValid = cnt_q != '0;
    assign evtData  = mem_q[rp_q];
    assign evtCount = cnt_q;
    assign overflow = ovf_q;
endmodule

// File: tb/tb_ps2_key_event_queue.sv
// tb_ps2_key_event_queue: scoreboard bench with a prefix-flag/lookup-table reference model
module tb_ps2_key_event_queue;
    localparam int AW = 9, DW = 32, D = 16, CW = $clog2(D) + 1;
    logic clk = 1'b0, rst = 1'b1, scr = 1'b0, pop = 1'b0, ovc = 1'b0;
    logic [7:0] sc = 8'h00;
    logic [AW-1:0] addr = '0;
    logic [DW-1:0] kv0, kv1;
    logic v0, v1, o0, o1;
    logic [15:0] d0, d1;
    logic [CW-1:0] c0, c1;
    int errors = 0, checks = 0, pop_mode = 1;

    always #5 clk = ~clk;

    ps2_key_event_queue #(.ADDR_W(AW), .DATA_W(DW), .FIFO_DEPTH(D), .REPEAT_FILTER(1)) dut (
        .clk(clk), .rst(rst), .scanCode(sc), .scanCodeReady(scr), .asciiKeyAddress(addr),
        .keyValue(kv0), .evtPop(pop), .evtValid(v0), .evtData(d0), .evtCount(c0),
        .overflow(o0), .ovfClear(ovc));
    ps2_key_event_queue #(.ADDR_W(AW), .DATA_W(DW), .FIFO_DEPTH(D), .REPEAT_FILTER(0)) dut_nf (
        .clk(clk), .rst(rst), .scanCode(sc), .scanCodeReady(scr), .asciiKeyAddress(addr),
        .keyValue(kv1), .evtPop(1'b0), .evtValid(v1), .evtData(d1), .evtCount(c1),
        .overflow(o1), .ovfClear(1'b0));

    logic [7:0] letter_sc [26] = '{8'h1C, 8'h32, 8'h21, 8'h23, 8'h24, 8'h2B, 8'h34, 8'h33, 8'h43,
        8'h3B, 8'h42, 8'h4B, 8'h3A, 8'h31, 8'h44, 8'h4D, 8'h15, 8'h2D, 8'h1B, 8'h2C, 8'h3C, 8'h2A,
        8'h1D, 8'h22, 8'h35, 8'h1A};
    logic [7:0] digit_sc [10] = '{8'h45, 8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E, 8'h36, 8'h3D, 8'h3E, 8'h46};
    logic [AW-1:0] apick [12] = '{9'h061, 9'h041, 9'h062, 9'h042, 9'h063, 9'h043, 9'h100, 9'h101,
        9'h102, 9'h103, 9'h020, 9'h031};

    int nmap [int], emap [int];
    int keys_n [$], keys_e [$];
    bit ks [512];
    bit lsh, rsh, lct, rct, lal, ral, f0, e0, movf;
    logic [15:0] exp_q [$];
    logic [31:0] exp_kv = '0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    function automatic bit mread(input int a);
        return a == 256 ? (lsh | rsh) : a == 257 ? (lct | rct) : a == 258 ? (lal | ral) : ks[a];
    endfunction

    // Reference: prefixes are remembered as flags; a non-prefix byte finishes the code.
    task automatic model_byte(input logic [7:0] b);
        int code, ec;
        bit mk, held, sh;
        logic [15:0] ev;
        if (b == 8'hE1) return;
        if (b == 8'hF0 && !f0) begin f0 = 1'b1; return; end
        if (b == 8'hE0 && !e0) begin e0 = 1'b1; return; end
        mk = !f0;
        if (e0 ? emap.exists(int'(b)) : nmap.exists(int'(b))) begin
            code = e0 ? emap[int'(b)] : nmap[int'(b)];
            sh = lsh | rsh;
            ec = code;
            if (code == 256) begin
                if (b == 8'h12) begin held = lsh; lsh = mk; end else begin held = rsh; rsh = mk; end
            end else if (code == 257) begin
                if (e0) begin held = rct; rct = mk; end else begin held = lct; lct = mk; end
            end else if (code == 258) begin
                if (e0) begin held = ral; ral = mk; end else begin held = lal; lal = mk; end
            end else if (code >= 'h61 && code <= 'h7A) begin
                held = ks[code] | ks[code - 32];
                if (sh) ec = code - 32;
                if (mk) ks[ec] = 1'b1;
                else begin ks[code] = 1'b0; ks[code - 32] = 1'b0; end
            end else begin
                held = ks[code];
                ks[code] = mk;
            end
            if (!(mk && held)) begin
                ev = {mk, lsh | rsh, lct | rct, lal | ral, e0, 2'b00, 9'(ec)};
                if (exp_q.size() < D) exp_q.push_back(ev);
                else movf = 1'b1;
            end
        end
        f0 = 1'b0;
        e0 = 1'b0;
    endtask

    initial forever begin
        @(posedge clk);
        if (rst) begin
            foreach (ks[i]) ks[i] = 1'b0;
            {lsh, rsh, lct, rct, lal, ral, f0, e0, movf} = '0;
            exp_q.delete();
            exp_kv = '0;
        end else begin
            exp_kv = 32'(mread(int'(addr)));
            if (pop && exp_q.size() > 0) void'(exp_q.pop_front());
            if (ovc) movf = 1'b0;
            if (scr) model_byte(sc);
        end
    end

    initial begin
        @(posedge clk);
        forever begin
            @(negedge clk);
            check("evtValid", 32'(v0), 32'(exp_q.size() > 0));
            check("evtCount", 32'(c0), 32'(exp_q.size()));
            check("overflow", 32'(o0), 32'(movf));
            check("keyValue", kv0, exp_kv);
            if (v0 && exp_q.size() > 0) check("evtData", 32'(d0), 32'(exp_q[0]));
            pop = pop_mode == 0 ? 1'($urandom_range(0, 1)) : pop_mode == 2 ? scr : 1'b0;
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
        scr = 1'b0;
        ovc = 1'b0;
        addr = apick[$urandom_range(0, 11)];
    endtask

    task automatic send(input logic [7:0] b);
        cyc();
        sc = b;
        scr = 1'b1;
    endtask

    task automatic idle(input int n);
        repeat (n) cyc();
    endtask

    task automatic do_reset(input int n);
        cyc();
        rst = 1'b1;
        idle(n);
        rst = 1'b0;
    endtask

    task automatic read_key(input string name, input logic [AW-1:0] a, input logic [31:0] exp);
        cyc();
        addr = a;
        @(posedge clk);
        #2;
        check(name, kv0, exp);
    endtask

    initial begin
        int r;
        bit ex, bk;
        logic [7:0] b;
        for (int i = 0; i < 26; i++) nmap[int'(letter_sc[i])] = 'h61 + i;
        for (int i = 0; i < 10; i++) nmap[int'(digit_sc[i])] = 'h30 + i;
        nmap['h29] = 'h20; nmap['h5A] = 'h0D; nmap['h76] = 'h1B; nmap['h66] = 'h08; nmap['h0D] = 'h09;
        nmap['h12] = 256; nmap['h59] = 256; nmap['h14] = 257; nmap['h11] = 258;
        emap['h75] = 259; emap['h72] = 260; emap['h6B] = 261; emap['h74] = 262;
        emap['h14] = 257; emap['h11] = 258;
        foreach (nmap[k]) keys_n.push_back(k);
        foreach (emap[k]) keys_e.push_back(k);
        keys_n.push_back('h0E); keys_n.push_back('h61); keys_n.push_back('h7C);
        keys_e.push_back('h12); keys_e.push_back('h7C);

        idle(3);
        rst = 1'b0;
        check("rst_valid", 32'(v0), 32'd0);
        check("rst_count", 32'(c0), 32'd0);
        check("rst_ovf", 32'(o0), 32'd0);
        check("rst_kv", kv0, 32'd0);

        send(8'h1C);
        read_key("a_make", 9'h061, 32'd1);
        check("a_make_evt", 32'(d0), 32'h8061);
        send(8'hF0); send(8'h1C);
        read_key("a_break", 9'h061, 32'd0);
        pop_mode = 0;
        idle(10);

        send(8'h12); send(8'h59); send(8'hF0); send(8'h12); send(8'h1C);
        read_key("A_shift", 9'h041, 32'd1);
        read_key("shift_held", 9'h100, 32'd1);
        send(8'hF0); send(8'h59);
        read_key("shift_rel", 9'h100, 32'd0);
        send(8'hF0); send(8'h1C);
        read_key("A_clear", 9'h041, 32'd0);
        read_key("a_clear", 9'h061, 32'd0);

        pop_mode = 1;
        do_reset(2);
        send(8'hE0); send(8'h75);
        read_key("up_make", 9'h103, 32'd1);
        check("up_evt", 32'(d0), 32'h8903);
        send(8'hF0); send(8'hE0); send(8'h75);
        read_key("up_brk_f0e0", 9'h103, 32'd0);
        send(8'hE0); send(8'h75); send(8'hE0); send(8'hF0); send(8'h75);
        read_key("up_brk_e0f0", 9'h103, 32'd0);
        pop_mode = 0;
        idle(20);

        pop_mode = 1;
        do_reset(2);
        repeat (5) send(8'h1C);
        idle(2);
        check("filter_on_count", 32'(c0), 32'd1);
        check("filter_off_count", 32'(c1), 32'd5);
        send(8'hF0); send(8'h1C);
        pop_mode = 0;
        idle(20);

        pop_mode = 1;
        do_reset(2);
        for (int i = 0; i <= D; i++) send(letter_sc[i]);
        idle(2);
        check("full_count", 32'(c0), 32'(D));
        check("ovf_set", 32'(o0), 32'd1);
        cyc();
        ovc = 1'b1;
        cyc();
        check("ovf_cleared", 32'(o0), 32'd0);
        pop_mode = 2;
        send(letter_sc[D + 1]);
        cyc();
        pop_mode = 1;
        check("full_pushpop_count", 32'(c0), 32'(D));
        check("full_pushpop_ovf", 32'(o0), 32'd0);
        pop_mode = 0;
        idle(60);

        send(8'hF0);
        cyc();
        rst = 1'b1;
        sc = 8'h1C;
        scr = 1'b1;
        cyc();
        rst = 1'b0;
        read_key("rst_drop_byte", 9'h061, 32'd0);
        send(8'h1C);
        read_key("after_rst_make", 9'h061, 32'd1);

        repeat (1500) begin
            r = $urandom_range(0, 99);
            if (r < 2) begin
                cyc();
                rst = 1'b1;
                sc = 8'($urandom_range(0, 255));
                scr = 1'b1;
                cyc();
                rst = 1'b0;
            end else if (r < 6) send(8'hE1);
            else if (r < 9) send(8'($urandom_range(0, 255)));
            else begin
                ex = $urandom_range(0, 3) == 0;
                bk = $urandom_range(0, 1) == 1;
                b = ex ? 8'(keys_e[$urandom_range(0, keys_e.size() - 1)])
                       : 8'(keys_n[$urandom_range(0, keys_n.size() - 1)]);
                if (ex && bk && $urandom_range(0, 1) == 1) begin send(8'hF0); send(8'hE0); end
                else begin
                    if (ex) send(8'hE0);
                    if (bk) send(8'hF0);
                end
                send(b);
            end
            if ($urandom_range(0, 9) == 0) begin cyc(); ovc = 1'b1; end
            idle($urandom_range(0, 3));
        end

        pop_mode = 0;
        for (int i = 0; i < 400 && exp_q.size() > 0; i++) cyc();
        check("drain", 32'(exp_q.size()), 32'd0);
        idle(2);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
